// File: rtl/bpu_btb.sv
// Fully-associative branch target buffer with 1-cycle lookup and sweep invalidation.
// Optional return-address stack enabled by defining BPU_RAS_EN.
module bpu_btb #(
  parameter int N_ADDR_BITS = 32,
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 8,
  parameter int N_CNT_BITS  = 2,
  parameter int N_RAS       = 4,
  localparam int IDX_W      = $clog2(N_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [N_ADDR_BITS-1:0] req_pc,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic                   resp_taken,
  output logic [IDX_W-1:0]       resp_idx,
  output logic [N_DATA_BITS-1:0] resp_pc,
  input  logic                   upd_valid,
  input  logic                   upd_alloc,
  input  logic                   upd_taken,
  input  logic [IDX_W-1:0]       upd_idx,
  input  logic [N_ADDR_BITS-1:0] upd_bp_pc,
  input  logic [N_DATA_BITS-1:0] upd_tgt_pc,
  input  logic                   upd_ret,
  input  logic                   upd_call,
  input  logic                   inv_req,
  output logic                   busy
);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  localparam logic [N_CNT_BITS-1:0] CNT_T = N_CNT_BITS'(2**(N_CNT_BITS-1));
  localparam logic [N_CNT_BITS-1:0] CNT_N = N_CNT_BITS'(2**(N_CNT_BITS-1)-1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENTRIES-1);

  state_t                 r_state;
  logic [N_ENTRIES-1:0]   r_vld;
  logic [N_ENTRIES-1:0]   r_ret;
  logic [N_ADDR_BITS-1:0] r_tag [N_ENTRIES];
  logic [N_DATA_BITS-1:0] r_tgt [N_ENTRIES];
  logic [N_CNT_BITS-1:0]  r_cnt [N_ENTRIES];
  logic [IDX_W-1:0]       r_rr;
  logic [IDX_W-1:0]       r_sidx;

  logic                   w_acc;
  logic                   w_upd;
  logic                   w_hit;
  logic [IDX_W-1:0]       w_hidx;
  logic                   w_umatch;
  logic [IDX_W-1:0]       w_umidx;
  logic                   w_free;
  logic [IDX_W-1:0]       w_fidx;
  logic                   w_rtaken;
  logic [N_DATA_BITS-1:0] w_rpc;
  logic                   w_pop;

  function automatic logic [N_CNT_BITS-1:0] f_train(
    input logic [N_CNT_BITS-1:0] c,
    input logic                  t
  );
    if (t) return (&c) ? c : c + N_CNT_BITS'(1);
    else   return (c == '0) ? c : c - N_CNT_BITS'(1);
  endfunction

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_SWEEP);
  assign w_acc     = req_valid & req_ready;
  assign w_upd     = upd_valid & (r_state == S_IDLE) & ~inv_req;

  // Priority search: lowest-index lookup hit, update match and free slot
  always_comb begin
    w_hit    = 1'b0;
    w_hidx   = '0;
    w_umatch = 1'b0;
    w_umidx  = '0;
    w_free   = 1'b0;
    w_fidx   = '0;
    for (int i = N_ENTRIES-1; i >= 0; i--) begin
      if (r_vld[i] && r_tag[i] == req_pc) begin
        w_hit  = 1'b1;
        w_hidx = IDX_W'(i);
      end
      if (r_vld[i] && r_tag[i] == upd_bp_pc) begin
        w_umatch = 1'b1;
        w_umidx  = IDX_W'(i);
      end
      if (!r_vld[i]) begin
        w_free = 1'b1;
        w_fidx = IDX_W'(i);
      end
    end
  end

`ifdef BPU_RAS_EN
  localparam int RW = $clog2(N_RAS);

  logic [N_DATA_BITS-1:0] r_ras [N_RAS];
  logic [RW-1:0]          r_rtop;
  logic [RW:0]            r_rcnt;

  logic                   w_ras_use;
  logic                   w_push;
  logic [N_ADDR_BITS-1:0] w_nxt;
  logic [RW-1:0]          w_ptop;
  logic [RW:0]            w_pcnt;
  logic [RW-1:0]          w_ntop;
  logic [RW:0]            w_ncnt;

  assign w_ras_use = w_hit & r_ret[w_hidx] & (r_rcnt != '0);
  assign w_pop     = w_acc & w_ras_use;
  assign w_push    = w_upd & upd_call;
  assign w_nxt     = upd_bp_pc + N_ADDR_BITS'(4);
  assign w_ptop    = w_pop ? r_rtop - RW'(1) : r_rtop;
  assign w_pcnt    = w_pop ? r_rcnt - (RW+1)'(1) : r_rcnt;
  assign w_ntop    = w_push ? w_ptop + RW'(1) : w_ptop;
  assign w_ncnt    = !w_push ? w_pcnt :
                     (w_pcnt == (RW+1)'(N_RAS)) ? w_pcnt :
                     w_pcnt + (RW+1)'(1);

  // Prediction: returns with a live RAS entry take the stack top
  always_comb begin
    w_rtaken = w_hit & r_cnt[w_hidx][N_CNT_BITS-1];
    w_rpc    = w_hit ? r_tgt[w_hidx] : '0;
    if (w_ras_use) begin
      w_rtaken = 1'b1;
      w_rpc    = r_ras[r_rtop];
    end
  end

  // Circular return stack; oldest slot overwritten when full
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rtop <= '0;
      r_rcnt <= '0;
      for (int i = 0; i < N_RAS; i++) r_ras[i] <= '0;
    end else if (r_state == S_IDLE && inv_req) begin
      r_rtop <= '0;
      r_rcnt <= '0;
    end else begin
      if (w_pop || w_push) begin
        r_rtop <= w_ntop;
        r_rcnt <= w_ncnt;
      end
      if (w_push) r_ras[w_ntop] <= N_DATA_BITS'(w_nxt);
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{upd_call, r_ret};
  assign w_pop    = 1'b0;

  // Prediction straight from the table
  always_comb begin
    w_rtaken = w_hit & r_cnt[w_hidx][N_CNT_BITS-1];
    w_rpc    = w_hit ? r_tgt[w_hidx] : '0;
  end
`endif

  // Registered lookup response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_taken <= 1'b0;
      resp_idx   <= '0;
      resp_pc    <= '0;
    end else begin
      resp_valid <= w_acc;
      if (w_acc) begin
        resp_hit   <= w_hit;
        resp_taken <= w_rtaken;
        resp_idx   <= w_hidx;
        resp_pc    <= w_rpc;
      end
    end
  end

  // Table update, replacement pointer and invalidation sweep FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_vld   <= '0;
      r_ret   <= '0;
      r_rr    <= '0;
      r_sidx  <= '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inv_req) begin
            r_state <= S_SWEEP;
            r_sidx  <= '0;
          end else if (upd_valid) begin
            if (!upd_alloc) begin
              r_cnt[upd_idx] <= f_train(r_cnt[upd_idx], upd_taken);
            end else if (w_umatch) begin
              r_tgt[w_umidx] <= upd_tgt_pc;
              r_cnt[w_umidx] <= f_train(r_cnt[w_umidx], upd_taken);
            end else begin
              r_vld[w_free ? w_fidx : r_rr] <= 1'b1;
              r_ret[w_free ? w_fidx : r_rr] <= upd_ret;
              r_tag[w_free ? w_fidx : r_rr] <= upd_bp_pc;
              r_tgt[w_free ? w_fidx : r_rr] <= upd_tgt_pc;
              r_cnt[w_free ? w_fidx : r_rr] <= upd_taken ? CNT_T : CNT_N;
              if (!w_free) r_rr <= r_rr + IDX_W'(1);
            end
          end
        end
        S_SWEEP: begin
          r_vld[r_sidx] <= 1'b0;
          r_rr          <= '0;
          if (r_sidx == IDX_LAST) begin
            r_state <= S_IDLE;
            r_sidx  <= '0;
          end else begin
            r_sidx <= r_sidx + IDX_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
